// File: rtl/bcd_serial_adder.sv
// Multi-digit packed BCD adder that works one digit per clock, least
// significant digit first, reusing a single decimal-adjust stage and
// carrying the inter-digit carry in a register.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   augend,
    input  logic [4*DIGITS-1:0]   addend,
    input  logic                  carry_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry_out,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [4*DIGITS-1:0] a_reg;
    logic [4*DIGITS-1:0] b_reg;
    logic                carry;
    logic [IW-1:0]       index;

    logic [3:0] a_digit;
    logic [3:0] b_digit;
    logic [4:0] raw;
    logic [3:0] sum_digit;
    logic       carry_next;
    logic       digit_bad;
    logic       last;

    // Single-digit decimal adjust on the digit currently selected by index
    always_comb begin
        a_digit    = a_reg[4*index +: 4];
        b_digit    = b_reg[4*index +: 4];
        raw        = {1'b0, a_digit} + {1'b0, b_digit} + {4'b0000, carry};
        sum_digit  = raw[3:0];
        carry_next = 1'b0;
        if (raw > 5'd9) begin
            sum_digit  = raw[3:0] + 4'd6;
            carry_next = 1'b1;
        end
        digit_bad  = (a_digit > 4'd9) || (b_digit > 4'd9);
        last       = (index == LAST);
    end

    // State register; reset drops straight back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the busy/done status decoded from the state
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? ADD : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one digit written per ADD cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            index     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg     <= augend;
                        b_reg     <= addend;
                        carry     <= carry_in;
                        index     <= '0;
                        sum       <= '0;
                        carry_out <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                ADD: begin
                    sum[4*index +: 4] <= sum_digit;
                    carry             <= carry_next;
                    if (digit_bad) begin
                        err <= 1'b1;
                    end
                    if (last) begin
                        carry_out <= carry_next;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed cases plus randomized
// operands compared against a digit-by-digit decimal reference model.
module tb_bcd_serial_adder;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [15:0] augend;
    logic [15:0] addend;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        carry_out;
    logic        err;

    logic        start1;
    logic [3:0]  augend1;
    logic [3:0]  addend1;
    logic        carry_in1;
    logic        busy1;
    logic        done1;
    logic [3:0]  sum1;
    logic        carry_out1;
    logic        err1;

    int total;
    int bad;

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .augend    (augend),
        .addend    (addend),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .err       (err)
    );

    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .augend    (augend1),
        .addend    (addend1),
        .carry_in  (carry_in1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (carry_out1),
        .err       (err1)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal addition digit by digit, with the +6 adjust whenever
    // a digit total exceeds nine, so invalid digits follow the same rule.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                     input int n, output logic [31:0] s, output logic co,
                                     output logic e);
        int c;
        int da;
        int db;
        int t;
        int d;
        c = int'(ci);
        s = '0;
        e = 1'b0;
        for (int i = 0; i < n; i++) begin
            da = int'((a >> (4*i)) & 32'hF);
            db = int'((b >> (4*i)) & 32'hF);
            t  = da + db + c;
            if (t > 9) begin
                d = (t + 6) % 16;
                c = 1;
            end else begin
                d = t;
                c = 0;
            end
            s = s | (32'(d) << (4*i));
            if (da > 9 || db > 9) e = 1'b1;
        end
        co = (c != 0);
    endfunction

    function automatic logic [31:0] randBcd(input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) v = v | (32'($urandom_range(10, 15)) << (4*i));
            else                           v = v | (32'($urandom_range(0, 9)) << (4*i));
        end
        return v;
    endfunction

    // One full 4-digit operation: accept, count busy cycles, check result
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                 input string tag);
        logic [31:0] es;
        logic        eco;
        logic        eerr;
        int          cycles;
        refModel(32'(a), 32'(b), ci, 4, es, eco, eerr);
        augend   = a;
        addend   = b;
        carry_in = ci;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        augend   = 16'($urandom);
        addend   = 16'($urandom);
        carry_in = 1'($urandom);
        cycles   = 0;
        while (busy && cycles < 50) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_busy"}, 32'(cycles), 32'd4);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_sum"}, 32'(sum), es);
        checkOutput({tag, "_co"}, 32'(carry_out), 32'(eco));
        checkOutput({tag, "_err"}, 32'(err), 32'(eerr));
    endtask

    // One full single-digit operation on the DIGITS=1 instance
    task automatic applyStimulusOne(input logic [3:0] a, input logic [3:0] b, input logic ci,
                                    input string tag);
        logic [31:0] es;
        logic        eco;
        logic        eerr;
        int          cycles;
        refModel(32'(a), 32'(b), ci, 1, es, eco, eerr);
        augend1   = a;
        addend1   = b;
        carry_in1 = ci;
        start1    = 1'b1;
        @(posedge clk);
        #1;
        start1    = 1'b0;
        cycles    = 0;
        while (busy1 && cycles < 50) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_busy"}, 32'(cycles), 32'd1);
        checkOutput({tag, "_done"}, 32'(done1), 32'd1);
        checkOutput({tag, "_sum"}, 32'(sum1), es);
        checkOutput({tag, "_co"}, 32'(carry_out1), 32'(eco));
        checkOutput({tag, "_err"}, 32'(err1), 32'(eerr));
    endtask

    // Main sequence
    initial begin
        logic [31:0] es;
        logic        eco;
        logic        eerr;
        int          cnt;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        augend    = '0;
        addend    = '0;
        carry_in  = 1'b0;
        start1    = 1'b0;
        augend1   = '0;
        addend1   = '0;
        carry_in1 = 1'b0;

        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_co", 32'(carry_out), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(16'h0777, 16'h0777, 1'b1, "t1");
        checkOutput("t1_sum_abs", 32'(sum), 32'h1555);
        applyStimulus(16'h9999, 16'h0001, 1'b0, "t2a");
        checkOutput("t2a_sum_abs", 32'(sum), 32'h0000);
        checkOutput("t2a_co_abs", 32'(carry_out), 32'd1);
        applyStimulus(16'h0000, 16'h0000, 1'b1, "t2b");
        checkOutput("t2b_sum_abs", 32'(sum), 32'h0001);

        applyStimulus(16'h00A0, 16'h0000, 1'b0, "t3a");
        checkOutput("t3a_sum_abs", 32'(sum), 32'h0100);
        checkOutput("t3a_err_abs", 32'(err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t3_hold_done", 32'(done), 32'd0);
        checkOutput("t3_hold_err", 32'(err), 32'd1);
        checkOutput("t3_hold_sum", 32'(sum), 32'h0100);
        applyStimulus(16'h0001, 16'h0001, 1'b0, "t3b");
        checkOutput("t3b_err_abs", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        // Start during ADD is ignored; start during DONE is accepted
        augend   = 16'h1234;
        addend   = 16'h0999;
        carry_in = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        @(posedge clk);
        #1;
        augend   = 16'h5555;
        addend   = 16'h4444;
        carry_in = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cnt      = 2;
        while (!done && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        refModel(32'h1234, 32'h0999, 1'b0, 4, es, eco, eerr);
        checkOutput("t4_ign_lat", 32'(cnt), 32'd4);
        checkOutput("t4_ign_sum", 32'(sum), es);
        checkOutput("t4_ign_co", 32'(carry_out), 32'(eco));
        augend   = 16'h2468;
        addend   = 16'h1357;
        carry_in = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cnt      = 1;
        while (!done && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        refModel(32'h2468, 32'h1357, 1'b1, 4, es, eco, eerr);
        checkOutput("t4_done_gap", 32'(cnt), 32'd5);
        checkOutput("t4_b2b_sum", 32'(sum), es);
        checkOutput("t4_b2b_co", 32'(carry_out), 32'(eco));
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an addition
        augend   = 16'h123A;
        addend   = 16'h4321;
        carry_in = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t5_pre_busy", 32'(busy), 32'd1);
        checkOutput("t5_pre_err", 32'(err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_done", 32'(done), 32'd0);
        checkOutput("t5_rst_sum", 32'(sum), 32'd0);
        checkOutput("t5_rst_co", 32'(carry_out), 32'd0);
        checkOutput("t5_rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_idle_busy", 32'(busy), 32'd0);
        applyStimulus(16'h1234, 16'h4321, 1'b0, "t5");
        checkOutput("t5_sum_abs", 32'(sum), 32'h5555);

        // Single-digit instance
        applyStimulusOne(4'h8, 4'h9, 1'b1, "t6");
        checkOutput("t6_sum_abs", 32'(sum1), 32'h8);
        checkOutput("t6_co_abs", 32'(carry_out1), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulusOne(4'(randBcd(1)), 4'(randBcd(1)), 1'($urandom), "r1");
        end

        // Randomized 4-digit operations, some back-to-back from DONE
        for (int i = 0; i < 40; i++) begin
            applyStimulus(16'(randBcd(4)), 16'(randBcd(4)), 1'($urandom), "r4");
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
